// File: rtl/out_demux.sv
// Collects a 3-channel TDM sample stream into {ch0, ch1, ch2} frames and queues them
// in a small FIFO for a ready/valid consumer. Sticky flags report dropped frames and sync slips.
module out_demux #(
  parameter int W     = 11,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] In,
  input  logic                in_sync,
  output logic [3*W-1:0]      Out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                ovf,
  output logic                sync_err,
  input  logic                clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {HUNT, GOT0, GOT1, WAIT0} state_e;

  state_e                state_q, state_d;
  logic signed [W-1:0]   shadow0_q, shadow0_d;
  logic signed [W-1:0]   shadow1_q, shadow1_d;
  logic                  push, serr_ev;
  logic [3*W-1:0]        frame_in;

  logic [3*W-1:0]        mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, pop, wr_en, ovf_ev;
  logic                  ovf_q, ovf_d, serr_q, serr_d;

  // Frame assembler: a sync pulse always restarts a frame at ch0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    push      = 1'b0;
    serr_ev   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (in_sync) begin
          shadow0_d = In;
          state_d   = GOT0;
        end
      end
      GOT0: begin
        if (in_sync) begin
          serr_ev   = 1'b1;
          shadow0_d = In;
        end else begin
          shadow1_d = In;
          state_d   = GOT1;
        end
      end
      GOT1: begin
        if (in_sync) begin
          serr_ev   = 1'b1;
          shadow0_d = In;
          state_d   = GOT0;
        end else begin
          push    = 1'b1;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (in_sync) begin
          shadow0_d = In;
          state_d   = GOT0;
        end else begin
          serr_ev = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign frame_in = {shadow0_q, shadow1_q, In};

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign ovf_ev    = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (pop && !wr_en) count_d = count_q - 1'b1;
  end

  // Set wins over clear so an event in the clear cycle is never lost.
  assign ovf_d  = (ovf_q  & ~clr) | ovf_ev;
  assign serr_d = (serr_q & ~clr) | serr_ev;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      shadow0_q <= '0;
      shadow1_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      serr_q    <= serr_d;
      if (wr_en) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)   rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  // NOTE: storage is not reset; an empty count masks stale entries and Out is forced to zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= frame_in;
  end

  assign Out      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign ovf      = ovf_q;
  assign sync_err = serr_q;

endmodule

// File: tb/tb_out_demux.sv
// Self-checking bench for out_demux: directed scenarios plus a randomized stream,
// compared every cycle against a queue-based frame model.
module tb_out_demux;

  localparam int W     = 11;
  localparam int DEPTH = 2;

  logic                clk;
  logic                reset;
  logic signed [W-1:0] din;
  logic                in_sync;
  logic [3*W-1:0]      dout;
  logic                out_valid;
  logic                out_ready;
  logic                ovf;
  logic                sync_err;
  logic                clr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: partial-frame sample list, frame queue and flags.
  logic [W-1:0]   m_part [$];
  logic [3*W-1:0] m_q [$];
  bit             m_awaiting;
  bit             m_ovf;
  bit             m_serr;

  out_demux #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .In       (din),
    .in_sync  (in_sync),
    .Out      (dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ovf      (ovf),
    .sync_err (sync_err),
    .clr      (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] smp(input int v);
    return v[W-1:0];
  endfunction

  function automatic logic [3*W-1:0] fr(input int a, input int b, input int c);
    return {smp(a), smp(b), smp(c)};
  endfunction

  task automatic model_reset();
    m_part.delete();
    m_q.delete();
    m_awaiting = 1'b0;
    m_ovf      = 1'b0;
    m_serr     = 1'b0;
  endtask

  // Advances the model across one rising edge given the inputs present before it.
  task automatic model_step(input logic s, input logic [W-1:0] d, input logic r, input logic c);
    bit             do_pop, do_push, serr_ev, ovf_ev;
    logic [3*W-1:0] f;
    do_pop  = (m_q.size() > 0) && r;
    do_push = 1'b0;
    serr_ev = 1'b0;
    f       = '0;
    if (s) begin
      if (m_part.size() > 0) serr_ev = 1'b1;
      m_part.delete();
      m_part.push_back(d);
      m_awaiting = 1'b0;
    end else if (m_part.size() == 0) begin
      if (m_awaiting) begin
        serr_ev    = 1'b1;
        m_awaiting = 1'b0;
      end
    end else begin
      m_part.push_back(d);
      if (m_part.size() == 3) begin
        do_push = 1'b1;
        f = {m_part[0], m_part[1], m_part[2]};
        m_part.delete();
        m_awaiting = 1'b1;
      end
    end
    ovf_ev = do_push && (m_q.size() == DEPTH) && !do_pop;
    if (do_pop) void'(m_q.pop_front());
    if (do_push && !ovf_ev) m_q.push_back(f);
    if (c) begin
      m_ovf  = 1'b0;
      m_serr = 1'b0;
    end
    if (ovf_ev)  m_ovf  = 1'b1;
    if (serr_ev) m_serr = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    logic [3*W-1:0] exp_out;
    exp_out = (m_q.size() > 0) ? m_q[0] : '0;
    check({tag, "_valid"}, 64'(out_valid), 64'(m_q.size() > 0));
    check({tag, "_out"},   64'(dout),      64'(exp_out));
    check({tag, "_ovf"},   64'(ovf),       64'(m_ovf));
    check({tag, "_serr"},  64'(sync_err),  64'(m_serr));
  endtask

  // Drives one sample at the falling edge, then checks outputs at the next falling edge.
  task automatic cycle(input logic s, input logic [W-1:0] d, input logic r, input logic c);
    in_sync   = s;
    din       = d;
    out_ready = r;
    clr       = c;
    model_step(s, d, r, c);
    @(posedge clk);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic send_frame(input logic [3*W-1:0] f, input logic r);
    cycle(1'b1, f[3*W-1:2*W], r, 1'b0);
    cycle(1'b0, f[2*W-1:W],   r, 1'b0);
    cycle(1'b0, f[W-1:0],     r, 1'b0);
  endtask

  // Asserts reset between clock edges and checks that outputs clear without waiting for a clock.
  task automatic do_reset();
    #2;
    reset     = 1'b0;
    in_sync   = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    clr       = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_out",   64'(dout),      64'(0));
    check("rst_ovf",   64'(ovf),       64'(0));
    check("rst_serr",  64'(sync_err),  64'(0));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int p;
    reset     = 1'b0;
    in_sync   = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    clr       = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Aligned stream with the consumer always ready.
    cycle(1'b1, smp(5),     1'b1, 1'b0);
    cycle(1'b0, smp(-3),    1'b1, 1'b0);
    check("s1_valid_early", 64'(out_valid), 64'(0));
    cycle(1'b0, smp(1023),  1'b1, 1'b0);
    check("s1_frame0_valid", 64'(out_valid), 64'(1));
    check("s1_frame0", 64'(dout), 64'(fr(5, -3, 1023)));
    cycle(1'b1, smp(-1024), 1'b1, 1'b0);
    cycle(1'b0, smp(0),     1'b1, 1'b0);
    cycle(1'b0, smp(7),     1'b1, 1'b0);
    check("s1_frame1", 64'(dout), 64'(fr(-1024, 0, 7)));
    check("s1_ovf",    64'(ovf),      64'(0));
    check("s1_serr",   64'(sync_err), 64'(0));

    // Backpressure: third frame dropped, then exactly two pops.
    do_reset();
    send_frame(fr(1, 2, 3), 1'b0);
    send_frame(fr(4, 5, 6), 1'b0);
    send_frame(fr(7, 8, 9), 1'b0);
    check("bp_ovf",  64'(ovf),  64'(1));
    check("bp_head", 64'(dout), 64'(fr(1, 2, 3)));
    cycle(1'b0, smp(0), 1'b1, 1'b0);
    check("bp_second", 64'(dout), 64'(fr(4, 5, 6)));
    cycle(1'b0, smp(0), 1'b1, 1'b0);
    check("bp_empty", 64'(out_valid), 64'(0));

    // Full FIFO with push and pop on the same edge.
    do_reset();
    send_frame(fr(11, 12, 13), 1'b0);
    send_frame(fr(21, 22, 23), 1'b0);
    cycle(1'b1, smp(31), 1'b0, 1'b0);
    cycle(1'b0, smp(32), 1'b0, 1'b0);
    cycle(1'b0, smp(33), 1'b1, 1'b0);
    check("pp_head", 64'(dout), 64'(fr(21, 22, 23)));
    check("pp_ovf",  64'(ovf),  64'(0));
    cycle(1'b1, smp(0), 1'b1, 1'b0);
    check("pp_tail", 64'(dout), 64'(fr(31, 32, 33)));
    cycle(1'b0, smp(0), 1'b1, 1'b0);
    check("pp_empty", 64'(out_valid), 64'(0));

    // Sync slip on the ch1 slot, then a missing sync in WAIT0.
    do_reset();
    cycle(1'b1, smp(10), 1'b1, 1'b0);
    cycle(1'b1, smp(20), 1'b1, 1'b0);
    check("slip_serr", 64'(sync_err), 64'(1));
    cycle(1'b0, smp(21), 1'b1, 1'b0);
    cycle(1'b0, smp(22), 1'b1, 1'b0);
    check("slip_frame", 64'(dout), 64'(fr(20, 21, 22)));
    for (int i = 0; i < 4; i++) cycle(1'b0, smp(99 + i), 1'b1, 1'b0);
    check("slip_nopush", 64'(out_valid), 64'(0));

    // Clear colliding with an overflow drop.
    do_reset();
    send_frame(fr(1, 1, 1), 1'b0);
    send_frame(fr(2, 2, 2), 1'b0);
    cycle(1'b1, smp(3), 1'b0, 1'b0);
    cycle(1'b0, smp(3), 1'b0, 1'b0);
    cycle(1'b0, smp(3), 1'b0, 1'b1);
    check("clr_setwins", 64'(ovf), 64'(1));
    cycle(1'b1, smp(4), 1'b0, 1'b1);
    check("clr_clears", 64'(ovf), 64'(0));

    // Reset mid-frame with one frame queued.
    do_reset();
    send_frame(fr(-5, 6, -7), 1'b0);
    cycle(1'b1, smp(8), 1'b0, 1'b0);
    cycle(1'b0, smp(9), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, smp(40 + i), 1'b1, 1'b0);
    check("mid_nohunt", 64'(out_valid), 64'(0));
    send_frame(fr(50, -51, 52), 1'b1);
    check("mid_recover", 64'(dout), 64'(fr(50, -51, 52)));

    // Randomized stream with occasional sync corruption, backpressure and clears.
    do_reset();
    p = 0;
    for (int i = 0; i < 3000; i++) begin
      logic s;
      s = (p == 0);
      if ($urandom_range(0, 99) < 4) s = ~s;
      cycle(s, W'($urandom()), ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 3));
      if ($urandom_range(0, 99) >= 2) p = (p + 1) % 3;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
